pia_port_pair: RTL and testbench

//   Parametrised 6520-style PIA core: two sides (A, B), each with data-direction register, output

---
 rtl/pia_port_pair.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_pia_port_pair.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pia_port_pair.sv
// pia_port_pair: two-sided 6520-style PIA core with width-parametrised ports,
// synchronised C1/C2 edge interrupts and handshake / timed-pulse / manual C2 outputs.

// One PIA side: DDR, OR, CR, interrupt flags and the C2 output sequencer.
module pia_side #(
    parameter int unsigned PORT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PULSE_CYCLES = 64,
    parameter bit          IS_B         = 1'b0
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  sel_port,
    input  logic                  sel_cr,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [PORT_WIDTH-1:0] data_i,
    input  logic [PORT_WIDTH-1:0] pins_i,
    input  logic                  c1_i,
    input  logic                  c2_i,
    output logic [PORT_WIDTH-1:0] port_rd_c,
    output logic [PORT_WIDTH-1:0] cr_rd_c,
    output logic [PORT_WIDTH-1:0] or_o,
    output logic [PORT_WIDTH-1:0] ddr_o,
    output logic                  c2_o,
    output logic                  c2_oe_o,
    output logic                  irq_n_o
);

    localparam int unsigned CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        C2_IDLE,
        C2_HS_LOW,
        C2_PULSE,
        C2_MANUAL
    } c2_state_t;

    logic [PORT_WIDTH-1:0]  or_q;
    logic [PORT_WIDTH-1:0]  ddr_q;
    logic [5:0]             cr_q;
    logic [5:0]             cr_nx;
    logic                   irq1_q;
    logic                   irq2_q;
    logic                   irq_n_q;
    logic                   c2_q;
    logic                   c2_nx;
    logic [SYNC_STAGES-1:0] c1_sync;
    logic [SYNC_STAGES-1:0] c2_sync;
    logic                   c1_prev;
    logic                   c2_prev;
    logic                   c1_edge;
    logic                   c2_edge;
    logic                   cr_write;
    logic                   or_write;
    logic                   or_read;
    logic                   trigger;
    c2_state_t              state_q;
    c2_state_t              state_nx;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_nx;

    // A side triggers C2 on reading ORA, B side on writing ORB; a write masks a simultaneous read.
    assign cr_write = wr & sel_cr;
    assign or_write = wr & sel_port & cr_q[2];
    assign or_read  = rd & ~wr & sel_port & cr_q[2];
    assign trigger  = IS_B ? or_write : or_read;

    assign c1_edge = cr_q[1] ? (c1_sync[SYNC_STAGES-1] & ~c1_prev)
                             : (~c1_sync[SYNC_STAGES-1] & c1_prev);
    assign c2_edge = cr_q[4] ? (c2_sync[SYNC_STAGES-1] & ~c2_prev)
                             : (~c2_sync[SYNC_STAGES-1] & c2_prev);

    // Read data: B side mixes output register with input pins, A side returns raw pins.
    assign port_rd_c = cr_q[2] ? (IS_B ? ((or_q & ddr_q) | (pins_i & ~ddr_q)) : pins_i)
                               : ddr_q;
    assign cr_rd_c   = PORT_WIDTH'({irq1_q, irq2_q, cr_q});

    assign or_o    = or_q;
    assign ddr_o   = ddr_q;
    assign c2_o    = c2_q;
    assign c2_oe_o = cr_q[5];
    assign irq_n_o = irq_n_q;

    // Data direction and output register writes.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            or_q  <= '0;
            ddr_q <= '0;
        end else if (wr && sel_port) begin
            if (cr_q[2]) begin
                or_q <= data_i;
            end else begin
                ddr_q <= data_i;
            end
        end
    end

    // Input synchronisers plus one-flop edge history; idle-high so reset raises no edge.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            c1_sync <= '1;
            c2_sync <= '1;
            c1_prev <= 1'b1;
            c2_prev <= 1'b1;
        end else begin
            c1_sync[0] <= c1_i;
            c2_sync[0] <= c2_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                c1_sync[i] <= c1_sync[i-1];
                c2_sync[i] <= c2_sync[i-1];
            end
            c1_prev <= c1_sync[SYNC_STAGES-1];
            c2_prev <= c2_sync[SYNC_STAGES-1];
        end
    end

    // Interrupt flags: an edge in the same cycle as the clearing read wins.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            irq1_q <= 1'b0;
            irq2_q <= 1'b0;
        end else begin
            if (c1_edge) begin
                irq1_q <= 1'b1;
            end else if (or_read) begin
                irq1_q <= 1'b0;
            end
            if (c2_edge && !cr_q[5]) begin
                irq2_q <= 1'b1;
            end else if (or_read) begin
                irq2_q <= 1'b0;
            end
        end
    end

    // Registered active-low interrupt request.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= ~((irq1_q & cr_q[0]) | (irq2_q & cr_q[3] & ~cr_q[5]));
        end
    end

    // C2 sequencer state, pulse counter, control register and C2 pin register.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= C2_IDLE;
            cnt_q   <= '0;
            cr_q    <= '0;
            c2_q    <= 1'b1;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            cr_q    <= cr_nx;
            c2_q    <= c2_nx;
        end
    end

    // Next state: a C2 mode change aborts any handshake or pulse in progress.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        cr_nx    = cr_q;
        c2_nx    = c2_q;

        if (cr_write) begin
            cr_nx = data_i[5:0];
        end

        if (cr_write && (data_i[5:3] != cr_q[5:3])) begin
            cnt_nx   = '0;
            state_nx = (data_i[5] && data_i[4]) ? C2_MANUAL : C2_IDLE;
        end else begin
            unique case (state_q)
                C2_IDLE: begin
                    if (cr_q[5] && cr_q[4]) begin
                        state_nx = C2_MANUAL;
                    end else if (cr_q[5] && trigger) begin
                        if (cr_q[3]) begin
                            state_nx = C2_PULSE;
                            cnt_nx   = CW'(PULSE_CYCLES - 1);
                        end else begin
                            state_nx = C2_HS_LOW;
                        end
                    end
                end
                C2_HS_LOW: begin
                    if (c1_edge) begin
                        state_nx = C2_IDLE;
                    end
                end
                C2_PULSE: begin
                    if (trigger) begin
                        cnt_nx = CW'(PULSE_CYCLES - 1);
                    end else if (cnt_q == '0) begin
                        state_nx = C2_IDLE;
                    end else begin
                        cnt_nx = cnt_q - CW'(1);
                    end
                end
                C2_MANUAL: begin
                    state_nx = C2_MANUAL;
                end
                default: begin
                    state_nx = C2_IDLE;
                end
            endcase
        end

        if (!cr_nx[5]) begin
            state_nx = C2_IDLE;
        end

        unique case (state_nx)
            C2_HS_LOW: c2_nx = 1'b0;
            C2_PULSE:  c2_nx = 1'b0;
            C2_MANUAL: c2_nx = cr_nx[3];
            default:   c2_nx = 1'b1;
        endcase
    end

endmodule

// Top: register-select decode and read mux over the two sides.
module pia_port_pair #(
    parameter int unsigned PORT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PULSE_CYCLES = 64
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [1:0]            rs_i,
    input  logic                  rd_strobe_i,
    input  logic                  wr_strobe_i,
    input  logic [PORT_WIDTH-1:0] data_i,
    output logic [PORT_WIDTH-1:0] data_o,
    input  logic [PORT_WIDTH-1:0] pa_i,
    input  logic [PORT_WIDTH-1:0] pb_i,
    output logic [PORT_WIDTH-1:0] pa_o,
    output logic [PORT_WIDTH-1:0] pb_o,
    output logic [PORT_WIDTH-1:0] pa_oe_o,
    output logic [PORT_WIDTH-1:0] pb_oe_o,
    input  logic                  ca1_i,
    input  logic                  cb1_i,
    input  logic                  ca2_i,
    input  logic                  cb2_i,
    output logic                  ca2_o,
    output logic                  cb2_o,
    output logic                  ca2_oe_o,
    output logic                  cb2_oe_o,
    output logic                  irqa_n_o,
    output logic                  irqb_n_o
);

    logic [PORT_WIDTH-1:0] a_port_rd;
    logic [PORT_WIDTH-1:0] a_cr_rd;
    logic [PORT_WIDTH-1:0] b_port_rd;
    logic [PORT_WIDTH-1:0] b_cr_rd;

    pia_side #(
        .PORT_WIDTH  (PORT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_CYCLES(PULSE_CYCLES),
        .IS_B        (1'b0)
    ) u_side_a (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .sel_port (rs_i == 2'd0),
        .sel_cr   (rs_i == 2'd1),
        .rd       (rd_strobe_i),
        .wr       (wr_strobe_i),
        .data_i   (data_i),
        .pins_i   (pa_i),
        .c1_i     (ca1_i),
        .c2_i     (ca2_i),
        .port_rd_c(a_port_rd),
        .cr_rd_c  (a_cr_rd),
        .or_o     (pa_o),
        .ddr_o    (pa_oe_o),
        .c2_o     (ca2_o),
        .c2_oe_o  (ca2_oe_o),
        .irq_n_o  (irqa_n_o)
    );

    pia_side #(
        .PORT_WIDTH  (PORT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_CYCLES(PULSE_CYCLES),
        .IS_B        (1'b1)
    ) u_side_b (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .sel_port (rs_i == 2'd2),
        .sel_cr   (rs_i == 2'd3),
        .rd       (rd_strobe_i),
        .wr       (wr_strobe_i),
        .data_i   (data_i),
        .pins_i   (pb_i),
        .c1_i     (cb1_i),
        .c2_i     (cb2_i),
        .port_rd_c(b_port_rd),
        .cr_rd_c  (b_cr_rd),
        .or_o     (pb_o),
        .ddr_o    (pb_oe_o),
        .c2_o     (cb2_o),
        .c2_oe_o  (cb2_oe_o),
        .irq_n_o  (irqb_n_o)
    );

    // Combinational register read mux.
    always_comb begin
        data_o = '0;
        unique case (rs_i)
            2'd0:    data_o = a_port_rd;
            2'd1:    data_o = a_cr_rd;
            2'd2:    data_o = b_port_rd;
            default: data_o = b_cr_rd;
        endcase
    end

endmodule

// File: tb/tb_pia_port_pair.sv
// Directed bench for pia_port_pair with a cycle-stamped expectation queue and a monitor.
module tb_pia_port_pair;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam int unsigned P = 8;

    localparam int SIG_DATA   = 0;
    localparam int SIG_PA_O   = 1;
    localparam int SIG_PB_O   = 2;
    localparam int SIG_PA_OE  = 3;
    localparam int SIG_PB_OE  = 4;
    localparam int SIG_CA2    = 5;
    localparam int SIG_CB2    = 6;
    localparam int SIG_CA2_OE = 7;
    localparam int SIG_CB2_OE = 8;
    localparam int SIG_IRQA   = 9;
    localparam int SIG_IRQB   = 10;

    logic         clock_i;
    logic         reset_n_i;
    logic [1:0]   rs_i;
    logic         rd_strobe_i;
    logic         wr_strobe_i;
    logic [W-1:0] data_i;
    logic [W-1:0] data_o;
    logic [W-1:0] pa_i;
    logic [W-1:0] pb_i;
    logic [W-1:0] pa_o;
    logic [W-1:0] pb_o;
    logic [W-1:0] pa_oe_o;
    logic [W-1:0] pb_oe_o;
    logic         ca1_i;
    logic         cb1_i;
    logic         ca2_i;
    logic         cb2_i;
    logic         ca2_o;
    logic         cb2_o;
    logic         ca2_oe_o;
    logic         cb2_oe_o;
    logic         irqa_n_o;
    logic         irqb_n_o;

    typedef struct {
        int         due;
        int         sig;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    pia_port_pair #(
        .PORT_WIDTH  (W),
        .SYNC_STAGES (S),
        .PULSE_CYCLES(P)
    ) dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .rs_i       (rs_i),
        .rd_strobe_i(rd_strobe_i),
        .wr_strobe_i(wr_strobe_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .pa_i       (pa_i),
        .pb_i       (pb_i),
        .pa_o       (pa_o),
        .pb_o       (pb_o),
        .pa_oe_o    (pa_oe_o),
        .pb_oe_o    (pb_oe_o),
        .ca1_i      (ca1_i),
        .cb1_i      (cb1_i),
        .ca2_i      (ca2_i),
        .cb2_i      (cb2_i),
        .ca2_o      (ca2_o),
        .cb2_o      (cb2_o),
        .ca2_oe_o   (ca2_oe_o),
        .cb2_oe_o   (cb2_oe_o),
        .irqa_n_o   (irqa_n_o),
        .irqb_n_o   (irqb_n_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    function automatic logic [7:0] sig_val(input int s);
        case (s)
            SIG_DATA:   return data_o;
            SIG_PA_O:   return pa_o;
            SIG_PB_O:   return pb_o;
            SIG_PA_OE:  return pa_oe_o;
            SIG_PB_OE:  return pb_oe_o;
            SIG_CA2:    return {7'd0, ca2_o};
            SIG_CB2:    return {7'd0, cb2_o};
            SIG_CA2_OE: return {7'd0, ca2_oe_o};
            SIG_CB2_OE: return {7'd0, cb2_oe_o};
            SIG_IRQA:   return {7'd0, irqa_n_o};
            default:    return {7'd0, irqb_n_o};
        endcase
    endfunction

    // Monitor: at each falling edge compare every expectation due in this cycle.
    initial begin
        forever begin
            @(negedge clock_i);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    logic [7:0] got;
                    got = sig_val(sb[i].sig);
                    compared++;
                    if (sb[i].due < cyc) begin
                        mismatched++;
                        $display("FAIL %s: missed sample cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                    end else if (got !== sb[i].exp) begin
                        mismatched++;
                        $display("FAIL %s: cycle %0d got %0h expected %0h", sb[i].name, cyc, got, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic expect_at(input string name, input int sig, input logic [7:0] exp, input int off);
        chk_t c;
        c.due  = cyc + off;
        c.sig  = sig;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] rs, input logic [7:0] d);
        rs_i        = rs;
        data_i      = d;
        wr_strobe_i = 1'b1;
        tick();
        wr_strobe_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] rs, input logic [7:0] exp, input string name);
        rs_i        = rs;
        rd_strobe_i = 1'b1;
        expect_at(name, SIG_DATA, exp, 0);
        tick();
        rd_strobe_i = 1'b0;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        rs_i        = 2'd0;
        rd_strobe_i = 1'b0;
        wr_strobe_i = 1'b0;
        data_i      = '0;
        pa_i        = 8'h5A;
        pb_i        = 8'h00;
        ca1_i       = 1'b1;
        cb1_i       = 1'b1;
        ca2_i       = 1'b1;
        cb2_i       = 1'b1;
        repeat (3) tick();
        reset_n_i = 1'b1;
        tick();

        // Reset values
        expect_at("rst_pa_oe", SIG_PA_OE, 8'h00, 0);
        expect_at("rst_ca2", SIG_CA2, 8'h01, 0);
        expect_at("rst_cb2", SIG_CB2, 8'h01, 0);
        expect_at("rst_irqa", SIG_IRQA, 8'h01, 0);
        reg_rd(2'd1, 8'h00, "rst_cra");

        // Port B mixed read
        reg_wr(2'd2, 8'hF0);
        reg_wr(2'd3, 8'h04);
        reg_wr(2'd2, 8'hA5);
        pb_i = 8'h3C;
        expect_at("pb_o", SIG_PB_O, 8'hA5, 0);
        expect_at("pb_oe", SIG_PB_OE, 8'hF0, 0);
        reg_rd(2'd2, 8'hAC, "portb_mix");

        // CA1 falling edge interrupt and latency
        reg_wr(2'd1, 8'h05);
        ca1_i = 1'b0;
        expect_at("irqa_before", SIG_IRQA, 8'h01, S + 1);
        expect_at("irqa_low", SIG_IRQA, 8'h00, S + 2);
        repeat (5) tick();
        reg_rd(2'd1, 8'h85, "cra_flag");
        reg_rd(2'd0, 8'h5A, "porta_pins");
        expect_at("irqa_still_low", SIG_IRQA, 8'h00, 0);
        expect_at("irqa_cleared", SIG_IRQA, 8'h01, 1);
        reg_rd(2'd1, 8'h05, "cra_cleared");

        // Edge lands in the same cycle as the clearing read: set wins
        ca1_i = 1'b1;
        repeat (5) tick();
        ca1_i = 1'b0;
        repeat (2) tick();
        reg_rd(2'd0, 8'h5A, "porta_race");
        expect_at("irqa_race_low", SIG_IRQA, 8'h00, 1);
        reg_rd(2'd1, 8'h85, "cra_set_wins");
        reg_rd(2'd0, 8'h5A, "porta_clear2");
        reg_rd(2'd1, 8'h05, "cra_cleared2");
        ca1_i = 1'b1;
        repeat (4) tick();

        // CB2 handshake
        reg_wr(2'd3, 8'h24);
        expect_at("cb2_oe", SIG_CB2_OE, 8'h01, 0);
        expect_at("cb2_idle", SIG_CB2, 8'h01, 0);
        reg_wr(2'd2, 8'h11);
        expect_at("pb_o_hs", SIG_PB_O, 8'h11, 0);
        expect_at("cb2_hs_low", SIG_CB2, 8'h00, 0);
        cb1_i = 1'b0;
        expect_at("cb2_hs_hold", SIG_CB2, 8'h00, S);
        expect_at("cb2_hs_done", SIG_CB2, 8'h01, S + 1);
        expect_at("irqb_masked", SIG_IRQB, 8'h01, S + 2);
        repeat (4) tick();
        reg_rd(2'd3, 8'hA4, "crb_hs_flag");
        cb1_i = 1'b1;
        reg_rd(2'd2, 8'h1C, "portb_clear");
        repeat (4) tick();

        // CA2 pulse mode
        reg_wr(2'd1, 8'h2C);
        expect_at("ca2_oe", SIG_CA2_OE, 8'h01, 0);
        expect_at("ca2_pre_pulse", SIG_CA2, 8'h01, 0);
        reg_rd(2'd0, 8'h5A, "porta_pulse");
        expect_at("ca2_pulse_start", SIG_CA2, 8'h00, 0);
        expect_at("ca2_pulse_last", SIG_CA2, 8'h00, P - 1);
        expect_at("ca2_pulse_end", SIG_CA2, 8'h01, P);
        repeat (P + 2) tick();

        // Retrigger mid-pulse extends the low period
        reg_rd(2'd0, 8'h5A, "porta_pulse2");
        repeat (2) tick();
        reg_rd(2'd0, 8'h5A, "porta_retrig");
        expect_at("ca2_extended", SIG_CA2, 8'h00, P - 3);
        expect_at("ca2_retrig_last", SIG_CA2, 8'h00, P - 1);
        expect_at("ca2_retrig_end", SIG_CA2, 8'h01, P);
        repeat (P + 2) tick();

        // Manual mode
        reg_wr(2'd1, 8'h34);
        expect_at("ca2_man_low", SIG_CA2, 8'h00, 0);
        reg_wr(2'd1, 8'h3C);
        expect_at("ca2_man_high", SIG_CA2, 8'h01, 0);
        tick();

        // Reset asserted mid-pulse
        reg_wr(2'd1, 8'h2C);
        reg_rd(2'd0, 8'h5A, "porta_pulse3");
        repeat (2) tick();
        expect_at("ca2_mid_pulse", SIG_CA2, 8'h00, 0);
        tick();
        reset_n_i = 1'b0;
        expect_at("rst2_ca2", SIG_CA2, 8'h01, 0);
        expect_at("rst2_ca2_oe", SIG_CA2_OE, 8'h00, 0);
        expect_at("rst2_cb2", SIG_CB2, 8'h01, 0);
        expect_at("rst2_cb2_oe", SIG_CB2_OE, 8'h00, 0);
        expect_at("rst2_irqa", SIG_IRQA, 8'h01, 0);
        expect_at("rst2_irqb", SIG_IRQB, 8'h01, 0);
        expect_at("rst2_pb_o", SIG_PB_O, 8'h00, 0);
        expect_at("rst2_pb_oe", SIG_PB_OE, 8'h00, 0);
        repeat (2) tick();
        reset_n_i = 1'b1;
        tick();
        reg_rd(2'd1, 8'h00, "cra_after_rst");
        reg_rd(2'd3, 8'h00, "crb_after_rst");

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: never sampled (due cycle %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
